// File: rtl/mem_to_axi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_to_axi (with soc_pkg AXI channel types)                   |
// | Description : Single-port memory req/gnt/rvalid initiator to single-beat   |
// |               AXI4 master; one outstanding transaction, word addresses     |
// |               rebased onto MEM_BASE. Optional MEM_TO_AXI_ERR_CNT_EN adds   |
// |               a saturating SLVERR/DECERR counter on err_cnt_o.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package soc_pkg;
    localparam int IW = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int UW = 1;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic          lock;
        logic [3:0]    cache;
        logic [2:0]    prot;
        logic [3:0]    qos;
        logic [3:0]    region;
        logic [5:0]    atop;
        logic [UW-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic          lock;
        logic [3:0]    cache;
        logic [2:0]    prot;
        logic [3:0]    qos;
        logic [3:0]    region;
        logic [UW-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
        logic [UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic [UW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [UW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } m_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } m_resp_t;
endpackage

module mem_to_axi #(
    parameter type         req_t    = soc_pkg::m_req_t,
    parameter type         resp_t   = soc_pkg::m_resp_t,
    parameter logic [63:0] MEM_BASE = 64'h0,
    parameter int          MEM_DW   = 64,
    parameter int          MEM_AW   = 16,
    parameter int          AXI_ID   = 0
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                mem_req_i,
    output logic                mem_gnt_o,
    input  logic                mem_we_i,
    input  logic [MEM_AW-1:0]   mem_addr_i,
    input  logic [MEM_DW-1:0]   mem_wdata_i,
    input  logic [MEM_DW/8-1:0] mem_strb_i,
    output logic                mem_rvalid_o,
    output logic [MEM_DW-1:0]   mem_rdata_o,
    output logic                mem_err_o,
`ifdef MEM_TO_AXI_ERR_CNT_EN
    output logic [15:0]         err_cnt_o,
`endif
    output req_t                req_o,
    input  resp_t               resp_i
);

    localparam int IW  = $bits(req_o.aw.id);
    localparam int AW  = $bits(req_o.aw.addr);
    localparam int DW  = $bits(req_o.w.data);
    localparam int OFF = $clog2(MEM_DW/8);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;

`ifdef SIMULATION
    if (MEM_DW != DW) begin : g_chk_dw
        $fatal(1, "mem_to_axi: MEM_DW must equal AXI data width");
    end
    if (MEM_AW + OFF > AW) begin : g_chk_aw
        $fatal(1, "mem_to_axi: MEM_AW does not fit the AXI address width");
    end
`endif

    logic [2:0]          state_q, state_d;
    logic [AW-1:0]       addr_q;
    logic [MEM_DW-1:0]   wdata_q;
    logic [MEM_DW/8-1:0] strb_q;
    logic                aw_done_q, w_done_q;
    logic                rvalid_q, err_q;
    logic [MEM_DW-1:0]   rdata_q;

    logic          w_accept, w_aw_valid, w_w_valid, w_ar_valid, w_b_ready, w_r_ready;
    logic          w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_cpl, w_cpl;
    logic [1:0]    w_cpl_resp;
    logic [AW-1:0] w_axi_addr;
    logic          w_unused;

    assign mem_gnt_o  = (state_q == S_IDLE);
    assign w_accept   = mem_req_i && mem_gnt_o;
    // Wraps modulo 2^AW by construction of the AW-bit sum.
    assign w_axi_addr = MEM_BASE[AW-1:0] + (AW'(mem_addr_i) << OFF);

    assign w_aw_valid = (state_q == S_WR_ADDR) && !aw_done_q;
    assign w_w_valid  = (state_q == S_WR_ADDR) && !w_done_q;
    assign w_ar_valid = (state_q == S_RD_ADDR);
    assign w_b_ready  = (state_q == S_WR_RESP);
    assign w_r_ready  = (state_q == S_RD_DATA);

    assign w_aw_hs    = w_aw_valid && resp_i.aw_ready;
    assign w_w_hs     = w_w_valid && resp_i.w_ready;
    assign w_ar_hs    = w_ar_valid && resp_i.ar_ready;
    assign w_b_hs     = w_b_ready && resp_i.b_valid;
    assign w_r_cpl    = w_r_ready && resp_i.r_valid && resp_i.r.last;
    assign w_cpl      = w_b_hs || w_r_cpl;
    assign w_cpl_resp = w_b_hs ? resp_i.b.resp : resp_i.r.resp;

    assign w_unused = ^{resp_i.b.id, resp_i.b.user, resp_i.r.id, resp_i.r.user};

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_accept) state_d = mem_we_i ? S_WR_ADDR : S_RD_ADDR;
            S_WR_ADDR: if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) state_d = S_WR_RESP;
            S_WR_RESP: if (w_b_hs) state_d = S_IDLE;
            S_RD_ADDR: if (w_ar_hs) state_d = S_RD_DATA;
            S_RD_DATA: if (w_r_cpl) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_o          = '0;
        req_o.aw.id    = IW'(AXI_ID);
        req_o.aw.addr  = addr_q;
        req_o.aw.size  = 3'($clog2(DW/8));
        req_o.aw.burst = 2'b01;
        req_o.aw_valid = w_aw_valid;
        req_o.w.data   = wdata_q;
        req_o.w.strb   = strb_q;
        req_o.w.last   = 1'b1;
        req_o.w_valid  = w_w_valid;
        req_o.b_ready  = w_b_ready;
        req_o.ar.id    = IW'(AXI_ID);
        req_o.ar.addr  = addr_q;
        req_o.ar.size  = 3'($clog2(DW/8));
        req_o.ar.burst = 2'b01;
        req_o.ar_valid = w_ar_valid;
        req_o.r_ready  = w_r_ready;
    end

    // Per-channel done flags let AW and W complete in either order.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (w_accept) begin
                addr_q    <= w_axi_addr;
                wdata_q   <= mem_wdata_i;
                strb_q    <= mem_strb_i;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (w_aw_hs) aw_done_q <= 1'b1;
                if (w_w_hs)  w_done_q  <= 1'b1;
            end
            rvalid_q <= w_cpl;
            if (w_cpl) begin
                rdata_q <= w_r_cpl ? resp_i.r.data : '0;
                err_q   <= (w_cpl_resp != 2'b00);
            end
        end
    end

    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
    assign mem_err_o    = err_q;

`ifdef MEM_TO_AXI_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Only SLVERR/DECERR count; EXOKAY still raises mem_err_o.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_cnt_q <= '0;
        end else if (w_cpl && w_cpl_resp[1] && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_to_axi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_to_axi                                                |
// | Description : Directed self-checking bench for mem_to_axi with a small    |
// |               AXI slave model.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_to_axi;

    logic clk = 1'b0;
    logic arst_ni;
    always #5 clk = ~clk;

    logic        mem_req_i, mem_we_i, mem_gnt_o, mem_rvalid_o, mem_err_o;
    logic [15:0] mem_addr_i;
    logic [63:0] mem_wdata_i, mem_rdata_o;
    logic [7:0]  mem_strb_i;
`ifdef MEM_TO_AXI_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif
    soc_pkg::m_req_t  req_o;
    soc_pkg::m_resp_t resp_i;

    mem_to_axi #(
        .MEM_BASE (64'h8000_0000),
        .MEM_DW   (64),
        .MEM_AW   (16),
        .AXI_ID   (0)
    ) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .mem_req_i    (mem_req_i),
        .mem_gnt_o    (mem_gnt_o),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_strb_i   (mem_strb_i),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_rdata_o  (mem_rdata_o),
        .mem_err_o    (mem_err_o),
`ifdef MEM_TO_AXI_ERR_CNT_EN
        .err_cnt_o    (err_cnt_o),
`endif
        .req_o        (req_o),
        .resp_i       (resp_i)
    );

    int total = 0;
    int bad   = 0;

    // slave configuration, written only by the main sequence
    int          aw_delay   = 0;
    logic        r_stall    = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [63:0] r_data_cfg = 64'h0;

    // slave observations, written only by the slave process
    int aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cnt = 0;
    int aw_valid_cyc = 0, w_valid_cyc = 0;
    logic aw_unstable = 1'b0;
    soc_pkg::aw_chan_t last_aw;
    soc_pkg::w_chan_t  last_w;
    soc_pkg::ar_chan_t last_ar;

    // Slave decides at the falling edge; handshakes land on the next rising edge.
    initial begin : slave
        int   aw_wait;
        logic aw_seen, w_seen, wr_pend, rd_pend, b_hs_pend, r_hs_pend, aw_was_valid;
        soc_pkg::aw_chan_t aw_prev;
        resp_i = '0;
        aw_wait = 0; aw_seen = 0; w_seen = 0; wr_pend = 0; rd_pend = 0;
        b_hs_pend = 0; r_hs_pend = 0; aw_was_valid = 0; aw_prev = '0;
        last_aw = '0; last_w = '0; last_ar = '0;
        forever begin
            @(negedge clk);
            if (!arst_ni) begin
                resp_i = '0;
                aw_wait = 0; aw_seen = 0; w_seen = 0; wr_pend = 0; rd_pend = 0;
                b_hs_pend = 0; r_hs_pend = 0; aw_was_valid = 0;
            end else begin
                if (b_hs_pend) begin resp_i.b_valid = 1'b0; b_hs_pend = 0; end
                if (r_hs_pend) begin resp_i.r_valid = 1'b0; r_hs_pend = 0; end
                if (wr_pend) begin
                    resp_i.b_valid = 1'b1; resp_i.b.resp = b_resp_cfg; wr_pend = 0;
                end
                if (rd_pend && !r_stall) begin
                    resp_i.r_valid = 1'b1; resp_i.r.data = r_data_cfg;
                    resp_i.r.resp = r_resp_cfg; resp_i.r.last = 1'b1; rd_pend = 0;
                end
                resp_i.aw_ready = 1'b0;
                if (req_o.aw_valid) begin
                    aw_valid_cyc++;
                    if (aw_was_valid && (req_o.aw != aw_prev)) aw_unstable = 1'b1;
                    aw_prev = req_o.aw;
                    if (aw_wait >= aw_delay) begin
                        resp_i.aw_ready = 1'b1; aw_wait = 0; aw_seen = 1;
                        aw_hs_cnt++; last_aw = req_o.aw;
                    end else begin
                        aw_wait++;
                    end
                end
                aw_was_valid = req_o.aw_valid && !resp_i.aw_ready;
                resp_i.w_ready = req_o.w_valid;
                if (req_o.w_valid) begin
                    w_valid_cyc++; w_seen = 1; w_hs_cnt++; last_w = req_o.w;
                end
                resp_i.ar_ready = req_o.ar_valid;
                if (req_o.ar_valid) begin
                    ar_hs_cnt++; last_ar = req_o.ar; rd_pend = 1;
                end
                if (aw_seen && w_seen) begin wr_pend = 1; aw_seen = 0; w_seen = 0; end
                if (resp_i.b_valid && req_o.b_ready) begin b_hs_pend = 1; b_hs_cnt++; end
                if (resp_i.r_valid && req_o.r_ready) r_hs_pend = 1;
            end
        end
    end

    // Issues one request; returns cycles from grant to rvalid (50 = timed out).
    task automatic run_txn(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                           input logic [7:0] st, output int lat,
                           output logic [63:0] rd, output logic er);
        int n = 0;
        while (!mem_gnt_o && n < 50) begin @(negedge clk); n++; end
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_strb_i = st;
        @(negedge clk);
        mem_req_i = 1'b0;
        lat = 1;
        while (!mem_rvalid_o && lat < 50) begin @(negedge clk); lat++; end
        rd = mem_rdata_o;
        er = mem_err_o;
    endtask

    task automatic test_reset();
        arst_ni = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_wdata_i = '0; mem_strb_i = '0;
        repeat (2) @(negedge clk);
        total++; if (mem_gnt_o !== 1'b1) begin bad++; $display("FAIL reset_gnt: got %b want 1", mem_gnt_o); end
        total++; if (req_o.aw_valid !== 1'b0 || req_o.w_valid !== 1'b0 || req_o.ar_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valids: got aw=%b w=%b ar=%b want 0", req_o.aw_valid, req_o.w_valid, req_o.ar_valid); end
        total++; if (req_o.b_ready !== 1'b0 || req_o.r_ready !== 1'b0) begin
            bad++; $display("FAIL reset_readies: got b=%b r=%b want 0", req_o.b_ready, req_o.r_ready); end
        total++; if (mem_rvalid_o !== 1'b0 || mem_err_o !== 1'b0 || mem_rdata_o !== 64'h0) begin
            bad++; $display("FAIL reset_mem_out: got rv=%b err=%b rd=%h want 0", mem_rvalid_o, mem_err_o, mem_rdata_o); end
`ifdef MEM_TO_AXI_ERR_CNT_EN
        total++; if (err_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_err_cnt: got %h want 0", err_cnt_o); end
`endif
        arst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int lat; logic [63:0] rd; logic er; int aw0 = aw_hs_cnt;
        run_txn(1'b1, 16'h0010, 64'h1122_3344_5566_7788, 8'hF0, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
        total++; if (rd !== 64'h0 || er !== 1'b0) begin bad++; $display("FAIL wr_completion: got rd=%h err=%b want 0/0", rd, er); end
        total++; if (last_aw.addr !== 32'h8000_0080) begin bad++; $display("FAIL wr_aw_addr: got %h want 80000080", last_aw.addr); end
        total++; if (last_aw.len !== 8'd0 || last_aw.size !== 3'd3 || last_aw.burst !== 2'b01 || last_aw.id !== 4'd0) begin
            bad++; $display("FAIL wr_aw_fields: got len=%0d size=%0d burst=%0d id=%0d want 0/3/1/0", last_aw.len, last_aw.size, last_aw.burst, last_aw.id); end
        total++; if (last_w.last !== 1'b1 || last_w.data !== 64'h1122_3344_5566_7788 || last_w.strb !== 8'hF0) begin
            bad++; $display("FAIL wr_w_fields: got last=%b data=%h strb=%h want 1/1122334455667788/f0", last_w.last, last_w.data, last_w.strb); end
        total++; if (aw_hs_cnt - aw0 !== 1) begin bad++; $display("FAIL wr_aw_count: got %0d want 1", aw_hs_cnt - aw0); end
        @(negedge clk);
        total++; if (mem_rvalid_o !== 1'b0) begin bad++; $display("FAIL wr_pulse_width: got %b want 0", mem_rvalid_o); end
    endtask

    task automatic test_read();
        int lat; logic [63:0] rd; logic er;
        r_data_cfg = 64'hDEAD_BEEF_0123_4567; r_resp_cfg = 2'b00;
        run_txn(1'b0, 16'h0003, 64'h0, 8'h00, lat, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency: got %0d want 3", lat); end
        total++; if (rd !== 64'hDEAD_BEEF_0123_4567 || er !== 1'b0) begin
            bad++; $display("FAIL rd_data: got rd=%h err=%b want deadbeef01234567/0", rd, er); end
        total++; if (last_ar.addr !== 32'h8000_0018 || last_ar.len !== 8'd0 || last_ar.size !== 3'd3) begin
            bad++; $display("FAIL rd_ar_fields: got addr=%h len=%0d size=%0d want 80000018/0/3", last_ar.addr, last_ar.len, last_ar.size); end
        @(negedge clk);
        total++; if (mem_rvalid_o !== 1'b0) begin bad++; $display("FAIL rd_pulse_width: got %b want 0", mem_rvalid_o); end
    endtask

    task automatic test_aw_delay();
        int lat; logic [63:0] rd; logic er;
        int awc0 = aw_valid_cyc, wc0 = w_valid_cyc, b0 = b_hs_cnt, aw0 = aw_hs_cnt;
        aw_delay = 4;
        run_txn(1'b1, 16'h0020, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, lat, rd, er);
        aw_delay = 0;
        total++; if (aw_valid_cyc - awc0 !== 5) begin bad++; $display("FAIL dly_aw_valid_cycles: got %0d want 5", aw_valid_cyc - awc0); end
        total++; if (w_valid_cyc - wc0 !== 1) begin bad++; $display("FAIL dly_w_valid_cycles: got %0d want 1", w_valid_cyc - wc0); end
        total++; if (aw_unstable !== 1'b0) begin bad++; $display("FAIL dly_aw_stable: got unstable=%b want 0", aw_unstable); end
        total++; if (b_hs_cnt - b0 !== 1 || aw_hs_cnt - aw0 !== 1) begin
            bad++; $display("FAIL dly_handshakes: got b=%0d aw=%0d want 1/1", b_hs_cnt - b0, aw_hs_cnt - aw0); end
        total++; if (lat !== 7) begin bad++; $display("FAIL dly_latency: got %0d want 7", lat); end
        @(negedge clk);
        total++; if (mem_rvalid_o !== 1'b0) begin bad++; $display("FAIL dly_pulse_width: got %b want 0", mem_rvalid_o); end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] rd; logic er;
        r_resp_cfg = 2'b11;
        run_txn(1'b0, 16'h0005, 64'h0, 8'h00, lat, rd, er);
        r_resp_cfg = 2'b00;
        total++; if (lat !== 3 || er !== 1'b1) begin bad++; $display("FAIL decerr_read: got lat=%0d err=%b want 3/1", lat, er); end
`ifdef MEM_TO_AXI_ERR_CNT_EN
        total++; if (err_cnt_o !== 16'd1) begin bad++; $display("FAIL decerr_count: got %0d want 1", err_cnt_o); end
`endif
        @(negedge clk);
        b_resp_cfg = 2'b10;
        run_txn(1'b1, 16'h0006, 64'h0, 8'h01, lat, rd, er);
        b_resp_cfg = 2'b00;
        total++; if (lat !== 3 || er !== 1'b1 || rd !== 64'h0) begin
            bad++; $display("FAIL slverr_write: got lat=%0d err=%b rd=%h want 3/1/0", lat, er, rd); end
`ifdef MEM_TO_AXI_ERR_CNT_EN
        total++; if (err_cnt_o !== 16'd2) begin bad++; $display("FAIL slverr_count: got %0d want 2", err_cnt_o); end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int gc[3]; logic rv_at[3]; int ng = 0; int rvcnt = 0; int aw0 = aw_hs_cnt;
        for (int i = 0; i < 3; i++) begin gc[i] = -1; rv_at[i] = 1'b0; end
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h0040;
        mem_wdata_i = 64'h0; mem_strb_i = 8'hFF;
        for (int c = 0; c < 12; c++) begin
            if (mem_req_i && mem_gnt_o && ng < 3) begin gc[ng] = c; rv_at[ng] = mem_rvalid_o; ng++; end
            if (mem_rvalid_o) rvcnt++;
            @(negedge clk);
            if (ng == 3) mem_req_i = 1'b0;
        end
        total++; if (ng !== 3 || gc[0] !== 0 || gc[1] !== 3 || gc[2] !== 6) begin
            bad++; $display("FAIL b2b_grants: got n=%0d at %0d,%0d,%0d want 3 at 0,3,6", ng, gc[0], gc[1], gc[2]); end
        total++; if (rv_at[1] !== 1'b1 || rv_at[2] !== 1'b1) begin
            bad++; $display("FAIL b2b_gnt_with_rvalid: got %b%b want 11", rv_at[1], rv_at[2]); end
        total++; if (rvcnt !== 3) begin bad++; $display("FAIL b2b_rvalid_pulses: got %0d want 3", rvcnt); end
        total++; if (aw_hs_cnt - aw0 !== 3) begin bad++; $display("FAIL b2b_aw_count: got %0d want 3", aw_hs_cnt - aw0); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic er; int n = 0;
        r_stall = 1'b1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 16'h0007;
        @(negedge clk);
        mem_req_i = 1'b0;
        while (!req_o.r_ready && n < 20) begin @(negedge clk); n++; end
        total++; if (req_o.r_ready !== 1'b1) begin bad++; $display("FAIL mid_reach_rd_data: got r_ready=%b want 1", req_o.r_ready); end
        #2 arst_ni = 1'b0;
        #1;
        total++; if (req_o.r_ready !== 1'b0 || req_o.ar_valid !== 1'b0 || mem_gnt_o !== 1'b1 || mem_rvalid_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset_outputs: got r_ready=%b ar_valid=%b gnt=%b rv=%b want 0/0/1/0",
                            req_o.r_ready, req_o.ar_valid, mem_gnt_o, mem_rvalid_o); end
`ifdef MEM_TO_AXI_ERR_CNT_EN
        total++; if (err_cnt_o !== 16'h0) begin bad++; $display("FAIL mid_reset_err_cnt: got %0d want 0", err_cnt_o); end
`endif
        @(negedge clk);
        r_stall = 1'b0;
        @(negedge clk);
        arst_ni = 1'b1;
        @(negedge clk);
        r_data_cfg = 64'h0123_4567_89AB_CDEF;
        run_txn(1'b0, 16'h0009, 64'h0, 8'h00, lat, rd, er);
        total++; if (lat !== 3 || rd !== 64'h0123_4567_89AB_CDEF || er !== 1'b0) begin
            bad++; $display("FAIL mid_post_read: got lat=%0d rd=%h err=%b want 3/0123456789abcdef/0", lat, rd, er); end
        total++; if (last_ar.addr !== 32'h8000_0048) begin bad++; $display("FAIL mid_post_addr: got %h want 80000048", last_ar.addr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_aw_delay();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
